// File: rtl/div_issue_wb.sv
// rtl/div_issue_wb.sv - RV32M divide/remainder sequencer between EX, divrem_top and writeback.
// Optional operand/result reuse cache is enabled with `define DIVREM_FUSE_EN.
module div_issue_wb #(
  parameter int RD_W   = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              cpurst,
  input  logic              ex_div_valid,
  input  logic [2:0]        ex_funct3,
  input  logic [DATA_W-1:0] ex_rs1,
  input  logic [DATA_W-1:0] ex_rs2,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_flush,
  output logic              div_stall,
  output logic [DATA_W-1:0] dividend,
  output logic [DATA_W-1:0] divider,
  output logic              divsigned,
  output logic              diven_p,
  input  logic              diven,
  input  logic              divout_valid,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] rem,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, DRAIN, DONE} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] dividend_q;
  logic [DATA_W-1:0] divider_q;
  logic              divsigned_q;
  logic [RD_W-1:0]   rd_q;
  logic              sel_rem_q;
  logic              wb_valid_q;
  logic [RD_W-1:0]   wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;

  logic              is_div_op;
  logic              accept;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              unused_diven;

  // Busy status from the divider is informational; sequencing relies on the strobe.
  assign unused_diven = diven;

  assign is_div_op = ex_div_valid & ex_funct3[2];
  assign accept    = (state_q == IDLE) & is_div_op & ~ex_flush;
  assign div_stall = is_div_op & ~ex_flush & ~((state_q == DONE) & wb_ready);
  assign diven_p   = (state_q == ISSUE) & ~ex_flush;

  assign dividend  = dividend_q;
  assign divider   = divider_q;
  assign divsigned = divsigned_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

`ifdef DIVREM_FUSE_EN
  logic [DATA_W-1:0] c_rs1_q;
  logic [DATA_W-1:0] c_rs2_q;
  logic [DATA_W-1:0] c_quo_q;
  logic [DATA_W-1:0] c_rem_q;
  logic              c_signed_q;
  logic              cvalid_q;

  assign hit = cvalid_q & (c_rs1_q == ex_rs1) & (c_rs2_q == ex_rs2)
             & (c_signed_q == ~ex_funct3[0]);
  assign hit_data = ex_funct3[1] ? c_rem_q : c_quo_q;

  // Only results of issued, non-drained divides are trusted for reuse.
  always_ff @(posedge clk or negedge cpurst) begin
    if (!cpurst) begin
      c_rs1_q    <= '0;
      c_rs2_q    <= '0;
      c_quo_q    <= '0;
      c_rem_q    <= '0;
      c_signed_q <= 1'b0;
      cvalid_q   <= 1'b0;
    end else if ((state_q == BUSY) && divout_valid) begin
      c_rs1_q    <= dividend_q;
      c_rs2_q    <= divider_q;
      c_quo_q    <= quo;
      c_rem_q    <= rem;
      c_signed_q <= divsigned_q;
      cvalid_q   <= 1'b1;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk or negedge cpurst) begin
    if (!cpurst) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divider_q   <= '0;
      divsigned_q <= 1'b0;
      rd_q        <= '0;
      sel_rem_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            dividend_q  <= ex_rs1;
            divider_q   <= ex_rs2;
            divsigned_q <= ~ex_funct3[0];
            rd_q        <= ex_rd;
            sel_rem_q   <= ex_funct3[1];
            if (hit) begin
              wb_data_q  <= hit_data;
              wb_rd_q    <= ex_rd;
              wb_valid_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: state_q <= ex_flush ? IDLE : BUSY;
        BUSY: begin
          if (divout_valid) begin
            if (ex_flush) begin
              state_q <= IDLE;
            end else begin
              wb_data_q  <= sel_rem_q ? rem : quo;
              wb_rd_q    <= rd_q;
              wb_valid_q <= 1'b1;
              state_q    <= DONE;
            end
          end else if (ex_flush) begin
            state_q <= DRAIN;
          end
        end
        // The divider cannot be aborted; hold off new work until its result is swallowed.
        DRAIN: if (divout_valid) state_q <= IDLE;
        DONE: begin
          if (ex_flush || wb_ready) begin
            wb_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_wb.sv
// tb/tb_div_issue_wb.sv - directed scoreboard bench for div_issue_wb with a behavioural divider.
module tb_div_issue_wb;

`ifdef DIVREM_FUSE_EN
  localparam bit FUSE = 1'b1;
`else
  localparam bit FUSE = 1'b0;
`endif
  localparam int LAT = 4;

  logic        clk;
  logic        cpurst;
  logic        ex_div_valid;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_flush;
  logic        div_stall;
  logic [31:0] dividend;
  logic [31:0] divider;
  logic        divsigned;
  logic        diven_p;
  logic        diven;
  logic        divout_valid;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int          checks;
  int          failures;
  int          pulse_cnt;
  int          dcnt;
  logic [63:0] res;
  logic [36:0] sb_q[$];

  div_issue_wb #(.RD_W(5), .DATA_W(32)) dut (
    .clk(clk), .cpurst(cpurst), .ex_div_valid(ex_div_valid), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_flush(ex_flush),
    .div_stall(div_stall), .dividend(dividend), .divider(divider), .divsigned(divsigned),
    .diven_p(diven_p), .diven(diven), .divout_valid(divout_valid), .quo(quo), .rem(rem),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rv_divrem(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Fixed-latency divrem_top stand-in.
  always @(posedge clk or negedge cpurst) begin
    if (!cpurst) begin
      divout_valid <= 1'b0;
      quo          <= 32'd0;
      rem          <= 32'd0;
      dcnt         <= 0;
      res          <= 64'd0;
      pulse_cnt    <= 0;
    end else begin
      divout_valid <= 1'b0;
      if (diven_p) pulse_cnt <= pulse_cnt + 1;
      if (dcnt != 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) begin
          divout_valid <= 1'b1;
          quo          <= res[63:32];
          rem          <= res[31:0];
        end
      end else if (diven_p) begin
        dcnt <= LAT;
        res  <= rv_divrem(dividend, divider, divsigned);
      end
    end
  end
  assign diven = (dcnt != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    ex_div_valid = 1'b1;
    ex_funct3    = f3;
    ex_rs1       = a;
    ex_rs2       = b;
    ex_rd        = rd;
  endtask

  task automatic finish_op(input string tag, input int p0, input int exp_pulse,
                           input int k_in, output int k);
    logic [36:0] e;
    k = k_in;
    while (!wb_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    e = sb_q.pop_front();
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
    if (wb_valid) begin
      chk({tag, "_data"}, wb_data, e[31:0]);
      chk({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, e[36:32]});
      chk({tag, "_stall_release"}, {31'd0, div_stall}, 32'd0);
      chk({tag, "_pulses"}, pulse_cnt - p0, exp_pulse);
    end
    @(negedge clk);
    ex_div_valid = 1'b0;
    chk({tag, "_wb_drop"}, {31'd0, wb_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_d,
                        input int exp_pulse);
    int p0;
    int k;
    @(negedge clk);
    drive(f3, a, b, rd);
    wb_ready = 1'b1;
    sb_q.push_back({rd, exp_d});
    p0 = pulse_cnt;
    #1;
    chk({tag, "_stall"}, {31'd0, div_stall}, 32'd1);
    @(negedge clk);
    chk({tag, "_divsigned"}, {31'd0, divsigned}, {31'd0, ~f3[0]});
    chk({tag, "_diven_p"}, {31'd0, diven_p}, exp_pulse);
    finish_op(tag, p0, exp_pulse, 1, k);
    chk({tag, "_latency"}, k, (exp_pulse != 0) ? LAT + 3 : 1);
  endtask

  initial begin
    int p0;
    int k;
    bit saw_wb;
    bit saw_dv;
    checks       = 0;
    failures     = 0;
    cpurst       = 1'b0;
    ex_div_valid = 1'b0;
    ex_funct3    = 3'd0;
    ex_rs1       = 32'd0;
    ex_rs2       = 32'd0;
    ex_rd        = 5'd0;
    ex_flush     = 1'b0;
    wb_ready     = 1'b0;
    #23;
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_diven_p", {31'd0, diven_p}, 32'd0);
    chk("rst_divsigned", {31'd0, divsigned}, 32'd0);
    chk("rst_dividend", dividend, 32'd0);
    chk("rst_divider", divider, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    @(negedge clk);
    cpurst = 1'b1;

    run_op("div_100_7", 3'b100, 32'd100, 32'd7, 5'd5, 32'd14, 1);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1);
    run_op("divu_big", 3'b101, 32'hFFFF_FFFF, 32'h10, 5'd8, 32'h0FFF_FFFF, 1);
    run_op("div_by0", 3'b100, 32'd55, 32'd0, 5'd10, 32'hFFFF_FFFF, 1);
    run_op("rem_by0", 3'b110, 32'd55, 32'd0, 5'd11, 32'd55, FUSE ? 0 : 1);

    // Non-divide M op must be invisible to this block.
    @(negedge clk);
    drive(3'b000, 32'd3, 32'd4, 5'd2);
    p0 = pulse_cnt;
    #1;
    chk("mul_no_stall", {31'd0, div_stall}, 32'd0);
    repeat (3) @(negedge clk);
    chk("mul_no_pulse", pulse_cnt - p0, 0);
    chk("mul_no_wb", {31'd0, wb_valid}, 32'd0);
    ex_div_valid = 1'b0;

    // Flush while the divider is busy, then a new op must wait for the stale strobe.
    @(negedge clk);
    drive(3'b100, 32'd20, 32'd4, 5'd3);
    p0 = pulse_cnt;
    @(negedge clk);
    @(negedge clk);
    chk("drain_issue_pulse", pulse_cnt - p0, 1);
    ex_flush     = 1'b1;
    ex_div_valid = 1'b0;
    @(negedge clk);
    ex_flush = 1'b0;
    drive(3'b100, 32'd9, 32'd3, 5'd7);
    sb_q.push_back({5'd7, 32'd3});
    p0 = pulse_cnt;
    #1;
    chk("drain_stall", {31'd0, div_stall}, 32'd1);
    saw_wb = 1'b0;
    saw_dv = 1'b0;
    k = 0;
    while (!saw_dv && k < 40) begin
      @(negedge clk);
      k++;
      if (wb_valid) saw_wb = 1'b1;
      if (divout_valid) saw_dv = 1'b1;
    end
    chk("drain_stale_strobe", {31'd0, saw_dv}, 32'd1);
    chk("drain_no_wb", {31'd0, saw_wb}, 32'd0);
    chk("drain_no_early_issue", pulse_cnt - p0, 0);
    finish_op("drain_div_9_3", p0, 1, 0, k);

    // Flush during the issue cycle suppresses the start pulse.
    @(negedge clk);
    drive(3'b100, 32'd50, 32'd5, 5'd4);
    p0 = pulse_cnt;
    @(negedge clk);
    chk("issue_pulse_pre", {31'd0, diven_p}, 32'd1);
    ex_flush = 1'b1;
    #1;
    chk("issue_flush_gate", {31'd0, diven_p}, 32'd0);
    chk("issue_flush_stall", {31'd0, div_stall}, 32'd0);
    @(negedge clk);
    ex_flush     = 1'b0;
    ex_div_valid = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    chk("issue_flush_no_pulse", pulse_cnt - p0, 0);
    chk("issue_flush_no_wb", {31'd0, wb_valid}, 32'd0);

    // Writeback back-pressure holds result and stall.
    @(negedge clk);
    drive(3'b101, 32'd1000, 32'd10, 5'd9);
    wb_ready = 1'b0;
    k = 0;
    while (!wb_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 4; i++) begin
      chk("bp_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("bp_wb_data", wb_data, 32'd100);
      chk("bp_wb_rd", {27'd0, wb_rd}, 32'd9);
      chk("bp_stall", {31'd0, div_stall}, 32'd1);
      @(negedge clk);
    end
    wb_ready = 1'b1;
    #1;
    chk("bp_stall_release", {31'd0, div_stall}, 32'd0);
    chk("bp_wb_data_final", wb_data, 32'd100);
    @(negedge clk);
    chk("bp_wb_drop", {31'd0, wb_valid}, 32'd0);
    ex_div_valid = 1'b0;

    run_op("fuse_div", 3'b100, 32'd100, 32'd7, 5'd1, 32'd14, 1);
    run_op("fuse_rem", 3'b110, 32'd100, 32'd7, 5'd2, 32'd2, FUSE ? 0 : 1);
    run_op("fuse_miss", 3'b100, 32'd100, 32'd8, 5'd3, 32'd12, 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_issue_wb.md
Name: div_issue_wb

Overview:
- Sequencer sitting between the EX stage and divrem_top.
- Accepts RV32M DIV/DIVU/REM/REMU from EX, registers operands, fires a one-cycle start pulse into the divider, waits for the result, selects quotient or remainder, and presents it to the writeback arbiter with a valid/ready handshake.
- Stalls EX while the operation is outstanding and handles pipeline flushes without corrupting the divider.

Parameters:
- RD_W, 5, destination register index width.
- DATA_W, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  core clock
- cpurst  in  1  reset, asynchronous, active-low
- ex_div_valid  in  1  EX holds an M-ext op
- ex_funct3  in  3  RV funct3; bit2=1 selects divide class
- ex_rs1  in  32  dividend source
- ex_rs2  in  32  divider source
- ex_rd  in  RD_W  destination register
- ex_flush  in  1  kill current EX op / in-flight divide
- div_stall  out  1  hold EX (combinational)
- dividend  out  32  to divrem_top (registered)
- divider  out  32  to divrem_top (registered)
- divsigned  out  1  to divrem_top (registered)
- diven_p  out  1  start pulse to divrem_top
- diven  in  1  divider busy (status only)
- divout_valid  in  1  one-cycle result strobe from divrem_top
- quo  in  32  quotient from divrem_top
- rem  in  32  remainder from divrem_top
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts
- wb_rd  out  RD_W  destination register
- wb_data  out  32  result

Behaviour:
- Reset (cpurst=0, async):
  - state=IDLE.
  - diven_p, wb_valid, divsigned = 0.
  - dividend, divider, wb_data = 0; wb_rd = 0.
  - kill flag cleared.
- accept = IDLE & ex_div_valid & ex_funct3[2] & !ex_flush.
  - On accept: latch rs1→dividend, rs2→divider, rd, funct3; divsigned = !funct3[0]; go ISSUE.
  - funct3[2]=0 is ignored by this block.
- ISSUE (1 cycle):
  - diven_p=1 → BUSY.
  - If ex_flush in this cycle: diven_p forced 0 → IDLE.
- BUSY:
  - Wait for divout_valid.
  - On the strobe: wb_data = funct3[1] ? rem : quo; wb_rd = latched rd → DONE.
  - ex_flush in BUSY → DRAIN.
- DRAIN:
  - Wait for divout_valid, discard the result → IDLE. No wb_valid.
  - The divider cannot be aborted, so a new op is never issued while it is busy.
- DONE:
  - wb_valid=1, with wb_data/wb_rd stable until wb_ready.
  - wb_valid & wb_ready → IDLE next edge.
  - ex_flush in DONE → drop wb_valid → IDLE.
- div_stall = ex_div_valid & ex_funct3[2] & !ex_flush & !(DONE & wb_ready).
  - EX advances on the same edge as the writeback handshake.
- Ignored events:
  - divout_valid outside BUSY/DRAIN is ignored.
  - A new op during DRAIN is stalled; it is accepted once back in IDLE.
- Divide-by-zero and overflow results (0xFFFFFFFF / dividend, 0x80000000 / 0) come from divrem_top and pass through unmodified.
- Minimum latency, accept edge → wb_valid: 2 + divider latency cycles.
- divout_valid coincident with ex_flush in BUSY: the result is discarded → IDLE directly.

Optional Feature:
- DIVREM_FUSE_EN defined:
  - Keep a cache of last {rs1, rs2, divsigned, quo, rem, cvalid}.
  - The cache is written on divout_valid in BUSY only.
  - On accept with cvalid and matching rs1/rs2/divsigned: skip ISSUE/BUSY, load wb_data from the cache (funct3[1] selects rem/quo) → DONE next cycle; diven_p never pulses.
  - cvalid is cleared on reset.
- DIVREM_FUSE_EN undefined:
  - No cache.
  - Every accepted op pulses diven_p.

Test Plan:
- Reset release, then DIV rs1=100, rs2=7, rd=5 → diven_p high exactly one cycle after accept, divsigned=1; on divout_valid wb_valid with wb_data=14, wb_rd=5.
- REM rs1=0xFFFFFFF9 (−7), rs2=2 → wb_data=0xFFFFFFFF. DIVU 0xFFFFFFFF/0x10 → wb_data=0x0FFFFFFF with divsigned=0.
- DIV rs1=55, rs2=0 → wb_data=0xFFFFFFFF. REM same operands → wb_data=55.
- Flush in BUSY → DRAIN, no wb_valid; a subsequent DIV 9/3 is issued only after the stale divout_valid, and returns 3.
- wb_ready held low 4 cycles in DONE → wb_valid/wb_data/wb_rd stable, div_stall=1; stall drops in the cycle wb_ready rises.
- With DIVREM_FUSE_EN: DIV 100/7 then REM 100/7 → second op has no diven_p pulse, wb_data=2 one cycle after accept. Changing rs2 to 8 forces a new issue.
